// File: rtl/enigma_responder.sv
// Port-c consumer for ENIGMA: accepts merged transfers, tracks outstanding ids, queues them,
// services each for a qos-dependent time, then pulses release and folds the payload into chk.
module enigma_responder #(
    parameter int PLD_W    = 128,
    parameter int ID_W     = 6,
    parameter int QOS_W    = 2,
    parameter int DEPTH    = 8,
    parameter int BASE_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_c,
    input  logic [PLD_W-1:0] payload_c,
    input  logic [ID_W-1:0]  id_c,
    input  logic [QOS_W-1:0] qos_c,
    input  logic             hold,
    output logic             ready_c,
    output logic             conflict_c,
    output logic             release_c,
    output logic [ID_W-1:0]  releaseid_c,
    output logic [31:0]      chk,
    output logic [15:0]      acc_cnt,
    output logic             busy
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int MAX_QOS = (1 << QOS_W) - 1;
    localparam int CNT_W   = $clog2(BASE_LAT + MAX_QOS + 1);
    localparam int NWORDS  = PLD_W / 32;

    // state | meaning: IDLE wait for queued entry, SERVE count service time, RELEASE retire head
    typedef enum logic [1:0] {IDLE, SERVE, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [2**ID_W-1:0] bitmap_q, bitmap_d;
    logic               conflict_q, conflict_d;
    logic               release_q, release_d;
    logic [ID_W-1:0]    releaseid_q, releaseid_d;
    logic [31:0]        chk_q, chk_d;
    logic [15:0]        acc_cnt_q, acc_cnt_d;

    logic [PLD_W-1:0]   pld_mem [DEPTH];
    logic [ID_W-1:0]    id_mem  [DEPTH];
    logic [QOS_W-1:0]   qos_mem [DEPTH];

    logic               full, accept, releasing, conflict_hit, push, pop;
    logic [PLD_W-1:0]   head_pld;
    logic [ID_W-1:0]    head_id;
    logic [QOS_W-1:0]   head_qos;
    logic [31:0]        head_fold;

    assign head_pld  = pld_mem[rd_ptr_q];
    assign head_id   = id_mem[rd_ptr_q];
    assign head_qos  = qos_mem[rd_ptr_q];

    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign ready_c   = ~rst & ~full & ~hold;
    assign accept    = valid_c & ready_c;
    assign releasing = (state_q == RELEASE);
    // The id retiring this cycle is cleared before being re-set, so it is not a conflict.
    assign conflict_hit = accept & bitmap_q[id_c] & ~(releasing & (head_id == id_c));
    assign push      = accept & ~conflict_hit;
    assign pop       = releasing;

    always_comb begin
        head_fold = '0;
        for (int i = 0; i < NWORDS; i++) begin
            head_fold = head_fold ^ head_pld[i*32 +: 32];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        bitmap_d    = bitmap_q;
        conflict_d  = conflict_hit;
        release_d   = pop;
        releaseid_d = pop ? head_id : '0;
        chk_d       = pop ? (chk_q ^ head_fold) : chk_q;
        acc_cnt_d   = accept ? (acc_cnt_q + 16'd1) : acc_cnt_q;

        if (pop) begin
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            bitmap_d[head_id] = 1'b0;
        end
        if (push) begin
            wr_ptr_d       = wr_ptr_q + PTR_W'(1);
            bitmap_d[id_c] = 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = SERVE;
                    cnt_d   = CNT_W'(BASE_LAT + MAX_QOS) - CNT_W'(head_qos);
                end
            end
            SERVE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            bitmap_q    <= '0;
            conflict_q  <= 1'b0;
            release_q   <= 1'b0;
            releaseid_q <= '0;
            chk_q       <= '0;
            acc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            bitmap_q    <= bitmap_d;
            conflict_q  <= conflict_d;
            release_q   <= release_d;
            releaseid_q <= releaseid_d;
            chk_q       <= chk_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            pld_mem[wr_ptr_q] <= payload_c;
            id_mem[wr_ptr_q]  <= id_c;
            qos_mem[wr_ptr_q] <= qos_c;
        end
    end

    assign conflict_c  = conflict_q;
    assign release_c   = release_q;
    assign releaseid_c = releaseid_q;
    assign chk         = chk_q;
    assign acc_cnt     = acc_cnt_q;
    assign busy        = (count_q != '0) | (state_q != IDLE);

endmodule
